// File: rtl/sw_pkg.sv
// Shared types and sizing for the switch pattern scanner.
package sw_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam int SW_WIDTH   = 8;
  localparam int RUN_W      = $clog2(SW_WIDTH + 1);
  localparam int PAIR_LEN   = 2;
  localparam int TRIPLE_LEN = 3;
endpackage

// File: rtl/sw_pattern_scanner_run_tracker.sv
// One-polarity run counter with saturating maximum and threshold flag.
// Next-state values are exported so the parent can publish the final bit in the same edge.
module run_tracker
  import sw_pkg::*;
#(
  parameter int   WIDTH    = SW_WIDTH,
  parameter logic POLARITY = 1'b1,
  parameter int   THRESH   = TRIPLE_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  output logic [RUN_W-1:0] max_nxt,
  output logic             flag_nxt
);

  logic [RUN_W-1:0] cur;
  logic [RUN_W-1:0] cur_nxt;
  logic [RUN_W-1:0] inc;
  logic [RUN_W-1:0] max_r;
  logic             flag_r;

  // Saturate at WIDTH so the counter can never wrap.
  assign inc = (cur == RUN_W'(WIDTH)) ? cur : cur + 1'b1;

  always_comb begin
    cur_nxt  = cur;
    max_nxt  = max_r;
    flag_nxt = flag_r;
    if (en) begin
      if (bit_in == POLARITY) begin
        cur_nxt = inc;
        if (inc > max_r)
          max_nxt = inc;
        if (inc >= RUN_W'(THRESH))
          flag_nxt = 1'b1;
      end else begin
        cur_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cur    <= '0;
      max_r  <= '0;
      flag_r <= 1'b0;
    end else begin
      cur    <= cur_nxt;
      max_r  <= max_nxt;
      flag_r <= flag_nxt;
    end
  end

endmodule

// File: rtl/sw_pattern_scanner.sv
// Latches the switch word on start, scans it LSB first one bit per cycle and
// publishes the pattern flags and longest runs with a one-cycle done pulse.
module sw_pattern_scanner
  import sw_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] sw,
  output logic             busy,
  output logic             done,
  output logic             led1,
  output logic             led2,
  output logic [RUN_W-1:0] max_one_run,
  output logic [RUN_W-1:0] max_zero_run
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             scan_en;
  logic             last;
  logic             cur_bit;
  logic [RUN_W-1:0] one_max_nxt;
  logic [RUN_W-1:0] zero_max_nxt;
  logic             one_flag_nxt;
  logic             zero_flag_nxt;

  assign accept  = (state == IDLE) && start;
  assign scan_en = (state == SCAN);
  assign last    = (idx == IDX_W'(WIDTH - 1));
  assign cur_bit = shadow[idx];

  run_tracker #(.WIDTH(WIDTH), .POLARITY(1'b1), .THRESH(TRIPLE_LEN)) u_ones (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (scan_en),
    .bit_in   (cur_bit),
    .max_nxt  (one_max_nxt),
    .flag_nxt (one_flag_nxt)
  );

  run_tracker #(.WIDTH(WIDTH), .POLARITY(1'b0), .THRESH(PAIR_LEN)) u_zeros (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (scan_en),
    .bit_in   (cur_bit),
    .max_nxt  (zero_max_nxt),
    .flag_nxt (zero_flag_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shadow       <= '0;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      led1         <= 1'b0;
      led2         <= 1'b0;
      max_one_run  <= '0;
      max_zero_run <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SCAN;
            busy   <= 1'b1;
            shadow <= sw;
            idx    <= '0;
          end
        end
        SCAN: begin
          idx <= idx + 1'b1;
          if (last) begin
            // Publish from next-state values so the last bit is included.
            state        <= DONE;
            done         <= 1'b1;
            led1         <= zero_flag_nxt;
            led2         <= one_flag_nxt & ~shadow[0];
            max_one_run  <= one_max_nxt;
            max_zero_run <= zero_max_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_pattern_scanner.sv
// Scoreboard bench: stimulus pushes reference results, a monitor checks every cycle.
module tb_sw_pattern_scanner;

  typedef struct packed {
    logic       led1;
    logic       led2;
    logic [3:0] m1;
    logic [3:0] m0;
  } res_t;

  typedef struct {
    res_t r;
    int   done_edge;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       busy, done, led1, led2;
  logic [3:0] max_one_run, max_zero_run;

  int    cyc = 0;
  int    total = 0;
  int    passed = 0;
  item_t q[$];
  int    acc_edge = -1000;
  int    next_free = 0;
  int    rst_edge = -1;
  bit    mon_on = 0;
  res_t  last_pub;

  sw_pattern_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sw           (sw),
    .busy         (busy),
    .done         (done),
    .led1         (led1),
    .led2         (led2),
    .max_one_run  (max_one_run),
    .max_zero_run (max_zero_run)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic res_t ref_scan(input logic [7:0] w);
    res_t r;
    int r1, r0;
    r = '0;
    r1 = 0;
    r0 = 0;
    for (int i = 0; i < 8; i++) begin
      if (w[i]) begin r1++; r0 = 0; end
      else      begin r0++; r1 = 0; end
      if (r1 > int'(r.m1)) r.m1 = 4'(r1);
      if (r0 > int'(r.m0)) r.m0 = 4'(r0);
    end
    for (int i = 0; i < 7; i++)
      if (!w[i] && !w[i+1]) r.led1 = 1'b1;
    if (!w[0])
      for (int i = 1; i < 6; i++)
        if (w[i] && w[i+1] && w[i+2]) r.led2 = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
  endtask

  // Called just after a falling edge; drives inputs for the next rising edge.
  task automatic step(input logic st, input logic [7:0] w, input logic r);
    int    e;
    item_t it;
    e = cyc + 1;
    rst = r;
    start = st;
    sw = w;
    if (r) begin
      q.delete();
      acc_edge = -1000;
      rst_edge = e;
      next_free = e + 1;
    end else if (st && e >= next_free) begin
      it.r = ref_scan(w);
      it.done_edge = e + 8;
      q.push_back(it);
      acc_edge = e;
      next_free = e + 10;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [7:0] w);
    for (int i = 0; i < n; i++) step(1'b0, w, 1'b0);
  endtask

  initial begin
    logic  exp_done, exp_busy;
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (cyc == rst_edge) begin
        mon_on = 1;
        last_pub = '0;
      end
      if (mon_on) begin
        exp_done = (q.size() > 0) && (q[0].done_edge == cyc);
        exp_busy = (cyc >= acc_edge) && (cyc <= acc_edge + 8);
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        if (exp_done) begin
          it = q.pop_front();
          last_pub = it.r;
          check("result", 32'({led1, led2, max_one_run, max_zero_run}), 32'(last_pub));
        end else begin
          check("hold", 32'({led1, led2, max_one_run, max_zero_run}), 32'(last_pub));
        end
      end
    end
  end

  initial begin
    logic [7:0] words [5];
    words[0] = 8'b0000_1110;
    words[1] = 8'hFF;
    words[2] = 8'h00;
    words[3] = 8'b0101_0101;
    words[4] = 8'b1110_0000;

    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    idle(2, 8'h00);

    foreach (words[i]) begin
      step(1'b1, words[i], 1'b0);
      idle(11, words[i]);
    end

    // Switch change and ignored start during a scan.
    step(1'b1, 8'b0000_1110, 1'b0);
    idle(2, 8'b0000_1110);
    step(1'b0, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    idle(10, 8'hFF);

    // Reset mid-scan, then a clean restart two cycles later.
    step(1'b1, 8'b0000_1110, 1'b0);
    idle(4, 8'b0000_1110);
    step(1'b1, 8'b0000_1110, 1'b1);
    idle(1, 8'b0000_1110);
    step(1'b1, 8'b1110_0000, 1'b0);
    idle(12, 8'b1110_0000);

    // Start held high re-triggers every ten cycles.
    for (int i = 0; i < 42; i++) step(1'b1, 8'b0000_1110, 1'b0);
    idle(12, 8'h00);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 80) == 0);
    step(1'b0, 8'h00, 1'b0);
    idle(14, 8'h00);

    check("drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
